ov7670_config_seq: RTL and testbench

Register-initialisation sequencer for the OV7670 camera. It walks an external synchronous ROM of 16-bit `{register, value}` entries and issues one SCCB write per entry through the existing SCCB transmitter using its `start`/`ready` handshake. It also executes inline delay entries and signals completion to the capture pipeline. It sits between the top-level reset/bring-up logic and the SCCB transmitter.

---
 rtl/ov7670_config_seq.sv | 189 ++++++++++++++++++
 tb/tb_ov7670_config_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_config_seq.sv
// ov7670_config_seq
//
// Register-initialisation sequencer for the OV7670 camera. Walks an external
// synchronous ROM of 16-bit {register, value} entries and issues one SCCB
// write per entry through the SCCB transmitter's start/ready handshake.
// Entry 16'hFFFF ends the table, 16'hFFF0 inserts a DELAY_CYCLES pause, any
// other value is a register write. The run also ends on the last ROM address
// (the address never wraps).
//
// Optional feature macro: CFG_SEQ_TIMEOUT_EN
//   defined   - watchdog on WAIT_ACCEPT + WAIT_DONE; expiry sets error and
//               finishes the run.
//   undefined - no watchdog, error is tied to 0.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   start_cfg     in   one-cycle request to run the table from entry 0
//   rom_addr      out  ROM read address
//   rom_data      in   ROM word, valid one cycle after rom_addr changes
//   sccb_ready    in   transmitter idle
//   sccb_start    out  one-cycle write request
//   sccb_address  out  register address to transmitter
//   sccb_data     out  register value to transmitter
//   busy          out  sequence in progress
//   done          out  table finished, held until next accepted start_cfg
//   error         out  watchdog fired
//   entry_count   out  SCCB writes issued in the current run

module ov7670_config_seq #(
    parameter int unsigned CLK_FREQ       = 25000000,
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned DELAY_CYCLES   = CLK_FREQ / 100,
    parameter int unsigned TIMEOUT_CYCLES = CLK_FREQ / 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_cfg,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    input  logic              sccb_ready,
    output logic              sccb_start,
    output logic [7:0]        sccb_address,
    output logic [7:0]        sccb_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   entry_count
);

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        WAIT_READY,
        SEND,
        WAIT_ACCEPT,
        WAIT_DONE,
        DELAY,
        DONE
    } state_t;

    localparam logic [15:0]       ENTRY_END   = 16'hFFFF;
    localparam logic [15:0]       ENTRY_DELAY = 16'hFFF0;
    localparam logic [ADDR_W-1:0] ADDR_ONE    = 1;
    localparam logic [ADDR_W:0]   CNT_ONE     = 1;

    if (DELAY_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("DELAY_CYCLES and TIMEOUT_CYCLES must be at least 1");
    end

    state_t      state;
    state_t      state_next;
    logic [31:0] dly_cnt;
    logic        last_addr;
    logic        timeout_hit;

    assign last_addr = (rom_addr == '1);

`ifdef CFG_SEQ_TIMEOUT_EN
    logic [31:0] wd_cnt;
    logic        in_xfer;

    assign in_xfer = (state == WAIT_ACCEPT) || (state == WAIT_DONE);

    // Cycles spent waiting on the transmitter for the current write.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
            error  <= 1'b0;
        end else begin
            wd_cnt <= in_xfer ? wd_cnt + 32'd1 : '0;
            if (state == IDLE && start_cfg)
                error <= 1'b0;
            else if (timeout_hit)
                error <= 1'b1;
        end
    end
`else
    assign error = 1'b0;
`endif

    always_comb begin
        state_next  = state;
        sccb_start  = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE:        if (start_cfg) state_next = FETCH;
            FETCH:       state_next = DECODE;
            DECODE: begin
                if (rom_data == ENTRY_END)
                    state_next = DONE;
                else if (rom_data == ENTRY_DELAY)
                    state_next = DELAY;
                else
                    state_next = WAIT_READY;
            end
            WAIT_READY:  if (sccb_ready) state_next = SEND;
            SEND: begin
                sccb_start = 1'b1;
                state_next = WAIT_ACCEPT;
            end
            WAIT_ACCEPT: if (!sccb_ready) state_next = WAIT_DONE;
            WAIT_DONE:   if (sccb_ready) state_next = last_addr ? DONE : FETCH;
            DELAY:       if (dly_cnt == '0) state_next = last_addr ? DONE : FETCH;
            DONE:        state_next = IDLE;
            default:     state_next = IDLE;
        endcase
`ifdef CFG_SEQ_TIMEOUT_EN
        // Watchdog expiry overrides whatever the handshake would have done.
        if (in_xfer && wd_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            timeout_hit = 1'b1;
            state_next  = DONE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rom_addr     <= '0;
            sccb_address <= '0;
            sccb_data    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            entry_count  <= '0;
            dly_cnt      <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start_cfg) begin
                        rom_addr    <= '0;
                        entry_count <= '0;
                        done        <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                DECODE: begin
                    if (rom_data == ENTRY_DELAY) begin
                        dly_cnt <= 32'(DELAY_CYCLES - 1);
                    end else if (rom_data != ENTRY_END) begin
                        sccb_address <= rom_data[15:8];
                        sccb_data    <= rom_data[7:0];
                    end
                end
                WAIT_DONE: begin
                    if (sccb_ready && !timeout_hit) begin
                        entry_count <= entry_count + CNT_ONE;
                        if (!last_addr) rom_addr <= rom_addr + ADDR_ONE;
                    end
                end
                DELAY: begin
                    if (dly_cnt == '0) begin
                        if (!last_addr) rom_addr <= rom_addr + ADDR_ONE;
                    end else begin
                        dly_cnt <= dly_cnt - 32'd1;
                    end
                end
                DONE: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Testbench for ov7670_config_seq: directed ROM tables with hand-computed
// expectations, a behavioural SCCB transmitter and a synchronous ROM model.
// DUT built with ADDR_W=2, DELAY_CYCLES=100, TIMEOUT_CYCLES=200.

module tb_ov7670_config_seq;

    localparam int unsigned ADDR_W  = 2;
    localparam int unsigned DLY     = 100;
    localparam int unsigned TIMEOUT = 200;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_cfg;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic              sccb_ready;
    logic              sccb_start;
    logic [7:0]        sccb_address;
    logic [7:0]        sccb_data;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   entry_count;

    ov7670_config_seq #(
        .CLK_FREQ      (25000000),
        .ADDR_W        (ADDR_W),
        .DELAY_CYCLES  (DLY),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_cfg   (start_cfg),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .sccb_ready  (sccb_ready),
        .sccb_start  (sccb_start),
        .sccb_address(sccb_address),
        .sccb_data   (sccb_data),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .entry_count (entry_count)
    );

    always #5 clk = ~clk;

    // Synchronous ROM
    logic [15:0] rom [4];
    always @(posedge clk) rom_data <= rom[rom_addr];

    // SCCB transmitter model: busy for xmit_len cycles after a start; no reset.
    int xmit_len = 6;
    bit hold_low = 1'b0;
    bit stuck    = 1'b0;
    int xbusy    = 0;
    always @(posedge clk) begin
        if (sccb_start)
            xbusy <= xmit_len;
        else if (xbusy > 0 && !stuck)
            xbusy <= xbusy - 1;
    end
    assign sccb_ready = !hold_low && (xbusy == 0);

    // Cycle counter and start-pulse monitor (sampled on the falling edge)
    int cyc = 0;
    always @(posedge clk) cyc++;

    int         n_start = 0;
    int         viol    = 0;
    int         last_start_cyc = 0;
    bit         prev_start = 1'b0;
    logic [7:0] log_a [$];
    logic [7:0] log_d [$];
    always @(negedge clk) begin
        if (sccb_start) begin
            n_start++;
            log_a.push_back(sccb_address);
            log_d.push_back(sccb_data);
            last_start_cyc = cyc;
            if (prev_start) viol++;
            if (!sccb_ready) viol++;
        end
        prev_start = sccb_start;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rom(input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3);
        rom[0] = e0; rom[1] = e1; rom[2] = e2; rom[3] = e3;
    endtask

    // Returns the cycle index of the edge that sampled start_cfg.
    task automatic pulse_start(output int n_edge);
        start_cfg = 1'b1;
        @(posedge clk);
        #1;
        n_edge    = cyc;
        start_cfg = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k = 0;
        while (!done && k < budget) begin
            tick(1);
            k++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic wait_starts(input int target, input int budget, input string tag);
        int k = 0;
        while (n_start < target && k < budget) begin
            tick(1);
            k++;
        end
        check({tag, "_start_seen"}, 32'(n_start >= target), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    int ne, base, lat0, lat1;

    initial begin
        rst       = 1'b1;
        start_cfg = 1'b0;
        set_rom(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tick(3);
        check("rst_rom_addr",    32'(rom_addr),     32'd0);
        check("rst_sccb_start",  32'(sccb_start),   32'd0);
        check("rst_sccb_addr",   32'(sccb_address), 32'd0);
        check("rst_sccb_data",   32'(sccb_data),    32'd0);
        check("rst_busy",        32'(busy),         32'd0);
        check("rst_done",        32'(done),         32'd0);
        check("rst_error",       32'(error),        32'd0);
        check("rst_entry_count", 32'(entry_count),  32'd0);
        rst = 1'b0;
        tick(2);

        // Single write then end marker
        set_rom(16'h1280, 16'hFFFF, 16'h0000, 16'h0000);
        base = n_start;
        pulse_start(ne);
        check("t1_busy_after_start", 32'(busy), 32'd1);
        wait_done(100, "t1");
        check("t1_num_starts", 32'(n_start - base), 32'd1);
        check("t1_addr",       32'(log_a[base]), 32'h12);
        check("t1_data",       32'(log_d[base]), 32'h80);
        check("t1_busy",       32'(busy), 32'd0);
        check("t1_entry_count", 32'(entry_count), 32'd1);
        check("t1_error",      32'(error), 32'd0);
        // start high in the cycle after edge N+3 (FETCH, DECODE, WAIT_READY, SEND)
        check("t1_latency",    32'(last_start_cyc - ne), 32'd3);

        // Baseline without delay entry
        tick(2);
        set_rom(16'h1101, 16'hFFFF, 16'h0000, 16'h0000);
        base = n_start;
        pulse_start(ne);
        wait_done(100, "t2a");
        lat0 = last_start_cyc - ne;
        check("t2a_latency", 32'(lat0), 32'd3);

        // Same write preceded by a delay entry: DLY cycles in DELAY plus the
        // FETCH and DECODE of the delay entry itself.
        tick(2);
        set_rom(16'hFFF0, 16'h1101, 16'hFFFF, 16'h0000);
        base = n_start;
        pulse_start(ne);
        wait_done(300, "t2b");
        lat1 = last_start_cyc - ne;
        check("t2b_delay_extra",  32'(lat1 - lat0), 32'(DLY + 2));
        check("t2b_num_starts",   32'(n_start - base), 32'd1);
        check("t2b_addr",         32'(log_a[base]), 32'h11);
        check("t2b_data",         32'(log_d[base]), 32'h01);
        check("t2b_entry_count",  32'(entry_count), 32'd1);

        // Backpressure: transmitter not ready for 50 cycles
        tick(2);
        set_rom(16'h3A04, 16'hFFFF, 16'h0000, 16'h0000);
        hold_low = 1'b1;
        base = n_start;
        pulse_start(ne);
        tick(50);
        check("t3_no_start_while_busy", 32'(n_start - base), 32'd0);
        check("t3_busy_held",           32'(busy), 32'd1);
        hold_low = 1'b0;
        wait_done(100, "t3");
        check("t3_num_starts", 32'(n_start - base), 32'd1);
        check("t3_addr",       32'(log_a[base]), 32'h3A);
        check("t3_data",       32'(log_d[base]), 32'h04);

        // Reset while waiting for a long transmission, then restart
        tick(2);
        xmit_len = 20;
        set_rom(16'h1280, 16'h1101, 16'h3A04, 16'hFFFF);
        base = n_start;
        pulse_start(ne);
        wait_starts(base + 1, 20, "t4");
        tick(5);
        check("t4_busy_pre_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        tick(1);
        check("t4_rst_busy",       32'(busy), 32'd0);
        check("t4_rst_sccb_start", 32'(sccb_start), 32'd0);
        check("t4_rst_rom_addr",   32'(rom_addr), 32'd0);
        rst = 1'b0;
        tick(1);
        base = n_start;
        pulse_start(ne);
        wait_done(300, "t4");
        check("t4_num_starts",   32'(n_start - base), 32'd3);
        check("t4_first_addr",   32'(log_a[base]), 32'h12);
        check("t4_last_addr",    32'(log_a[base + 2]), 32'h3A);
        check("t4_entry_count",  32'(entry_count), 32'd3);
        xmit_len = 6;

        // Full table without end marker: stops at last address
        tick(2);
        set_rom(16'h0101, 16'h0202, 16'h0303, 16'h0404);
        base = n_start;
        pulse_start(ne);
        wait_done(200, "t5");
        check("t5_num_starts",  32'(n_start - base), 32'd4);
        check("t5_entry_count", 32'(entry_count), 32'd4);
        check("t5_rom_addr",    32'(rom_addr), 32'd3);
        check("t5_first_data",  32'(log_d[base]), 32'h01);
        check("t5_last_addr",   32'(log_a[base + 3]), 32'h04);
        tick(3);
        check("t5_done_held",   32'(done), 32'd1);

        // Transmitter stuck busy after accepting a write
        tick(2);
        set_rom(16'h1280, 16'hFFFF, 16'h0000, 16'h0000);
        stuck = 1'b1;
        base = n_start;
        pulse_start(ne);
        wait_starts(base + 1, 20, "t6");
        tick(185);
`ifdef CFG_SEQ_TIMEOUT_EN
        check("t6_error_early", 32'(error), 32'd0);
        tick(25);
        check("t6_error", 32'(error), 32'd1);
        check("t6_done",  32'(done),  32'd1);
        check("t6_busy",  32'(busy),  32'd0);
`else
        check("t6_busy_early", 32'(busy), 32'd1);
        tick(25);
        check("t6_busy",  32'(busy),  32'd1);
        check("t6_error", 32'(error), 32'd0);
        check("t6_done",  32'(done),  32'd0);
`endif
        stuck = 1'b0;
        wait_done(100, "t6_recover");

        check("start_rules", 32'(viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
